// File: rtl/oc_chipmon_scan.sv
// Round-robin ADC channel scanner: requests conversions on enabled channels,
// averages 2^AvgLog2 samples per channel and raises hysteresis alarms.
module oc_chipmon_scan #(
  parameter int Channels      = 4,
  parameter int DataWidth     = 16,
  parameter int AvgLog2       = 2,
  parameter int TimeoutCycles = 1024,
  parameter int ChW           = (Channels > 1) ? $clog2(Channels) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [Channels-1:0]  enable,
  output logic                 convStart,
  output logic [ChW-1:0]       convChannel,
  input  logic                 sampleValid,
  input  logic [DataWidth-1:0] sampleData,
  input  logic                 thrWrite,
  input  logic [ChW-1:0]       thrChannel,
  input  logic                 thrSel,
  input  logic [DataWidth-1:0] thrData,
  input  logic [Channels-1:0]  stickyClear,
  output logic [Channels-1:0]  alarm,
  output logic [Channels-1:0]  alarmSticky,
  output logic                 avgValid,
  output logic [ChW-1:0]       avgChannel,
  output logic [DataWidth-1:0] avgData,
  output logic                 timeoutError,
  output logic [2:0]           dbgState
);

  // ADC handshake: convStart is a one-cycle request with no ready; the ADC
  // answers with a one-cycle sampleValid strobe carrying sampleData, which is
  // only taken in WAIT. avgValid is a one-cycle strobe with no backpressure.

  localparam int AccW  = DataWidth + AvgLog2;
  localparam int CntW  = AvgLog2 + 1;
  localparam int WaitW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [CntW-1:0]  AvgN     = CntW'(1 << AvgLog2);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TimeoutCycles - 1);
  localparam logic [ChW-1:0]   LastInit = ChW'(Channels - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    REQUEST = 3'd2,
    WAIT    = 3'd3,
    UPDATE  = 3'd4
  } scanState_e;

  scanState_e state;

  logic [ChW-1:0]       lastCh;
  logic [ChW-1:0]       nextCh;
  logic [WaitW-1:0]     waitCnt;
  logic                 killed;
  logic [AccW-1:0]      acc [Channels];
  logic [CntW-1:0]      cnt [Channels];
  logic [DataWidth-1:0] hiThr [Channels];
  logic [DataWidth-1:0] loThr [Channels];

  int                   scanIdx;
  logic [AccW-1:0]      accSum;
  logic [CntW-1:0]      cntInc;
  logic                 keepSample;
  logic [DataWidth-1:0] avgVal;
  logic [Channels-1:0]  alarmNext;

  assign dbgState = state;

  // Walk offsets from farthest to nearest so the nearest enabled channel after
  // lastCh is the one left in nextCh.
  always_comb begin
    nextCh  = lastCh;
    scanIdx = 0;
    for (int k = Channels; k >= 1; k--) begin
      scanIdx = int'(lastCh) + k;
      if (scanIdx >= Channels) scanIdx = scanIdx - Channels;
      if (enable[scanIdx]) nextCh = ChW'(scanIdx);
    end
  end

  always_comb begin
    accSum     = acc[convChannel] + AccW'(sampleData);
    cntInc     = cnt[convChannel] + CntW'(1);
    keepSample = enable[convChannel] && !killed;
    avgVal     = DataWidth'(acc[convChannel] >> AvgLog2);
    alarmNext  = alarm;
    if (avgVal > hiThr[convChannel]) begin
      alarmNext[convChannel] = 1'b1;
    end else if (alarm[convChannel] && (avgVal < loThr[convChannel])) begin
      alarmNext[convChannel] = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lastCh       <= LastInit;
      waitCnt      <= '0;
      killed       <= 1'b0;
      convStart    <= 1'b0;
      convChannel  <= '0;
      avgValid     <= 1'b0;
      avgChannel   <= '0;
      avgData      <= '0;
      alarm        <= '0;
      alarmSticky  <= '0;
      timeoutError <= 1'b0;
      for (int i = 0; i < Channels; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      convStart   <= 1'b0;
      avgValid    <= 1'b0;
      alarmSticky <= alarmSticky & ~stickyClear;
      case (state)
        IDLE: begin
          if (|enable) state <= SELECT;
        end
        SELECT: begin
          if (enable == '0) begin
            state <= IDLE;
          end else begin
            lastCh      <= nextCh;
            convChannel <= nextCh;
            convStart   <= 1'b1;
            killed      <= 1'b0;
            state       <= REQUEST;
          end
        end
        REQUEST: begin
          waitCnt <= '0;
          killed  <= !enable[convChannel];
          state   <= WAIT;
        end
        WAIT: begin
          // A channel disabled mid-flight still finishes WAIT, but its sample
          // must not land in the freshly cleared accumulator.
          if (!enable[convChannel]) killed <= 1'b1;
          if (sampleValid) begin
            if (keepSample) begin
              acc[convChannel] <= accSum;
              cnt[convChannel] <= cntInc;
              state            <= (cntInc == AvgN) ? UPDATE : SELECT;
            end else begin
              state <= SELECT;
            end
          end else if (waitCnt == WaitLast) begin
            timeoutError <= 1'b1;
            state        <= SELECT;
          end else begin
            waitCnt <= waitCnt + WaitW'(1);
          end
        end
        UPDATE: begin
          avgValid         <= 1'b1;
          avgChannel       <= convChannel;
          avgData          <= avgVal;
          alarm            <= alarmNext;
          alarmSticky      <= (alarmSticky & ~stickyClear) | (alarmNext & ~alarm);
          acc[convChannel] <= '0;
          cnt[convChannel] <= '0;
          state            <= SELECT;
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < Channels; i++) begin
        if (!enable[i]) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end
    end
  end

  // Thresholds are read by the UPDATE compare on the same edge they are written,
  // so a coincident write only affects the following comparison.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Channels; i++) begin
        hiThr[i] <= '1;
        loThr[i] <= '0;
      end
    end else if (thrWrite && (int'(thrChannel) < Channels)) begin
      if (thrSel) loThr[thrChannel] <= thrData;
      else        hiThr[thrChannel] <= thrData;
    end
  end

endmodule

// File: tb/tb_oc_chipmon_scan.sv
// Directed bench for oc_chipmon_scan: scan order, averaging, hysteresis,
// sticky alarms, timeout and mid-conversion reset.
module tb_oc_chipmon_scan;

  localparam int Channels      = 4;
  localparam int DataWidth     = 16;
  localparam int AvgLog2       = 2;
  localparam int TimeoutCycles = 16;
  localparam int ChW           = 2;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [Channels-1:0]  enable;
  logic                 convStart;
  logic [ChW-1:0]       convChannel;
  logic                 sampleValid;
  logic [DataWidth-1:0] sampleData;
  logic                 thrWrite;
  logic [ChW-1:0]       thrChannel;
  logic                 thrSel;
  logic [DataWidth-1:0] thrData;
  logic [Channels-1:0]  stickyClear;
  logic [Channels-1:0]  alarm;
  logic [Channels-1:0]  alarmSticky;
  logic                 avgValid;
  logic [ChW-1:0]       avgChannel;
  logic [DataWidth-1:0] avgData;
  logic                 timeoutError;
  logic [2:0]           dbgState;

  int testsRun    = 0;
  int failCount   = 0;
  int ch2Requests = 0;
  logic [ChW-1:0] exp_q[$];

  oc_chipmon_scan #(
    .Channels(Channels), .DataWidth(DataWidth), .AvgLog2(AvgLog2),
    .TimeoutCycles(TimeoutCycles), .ChW(ChW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .convStart(convStart), .convChannel(convChannel),
    .sampleValid(sampleValid), .sampleData(sampleData),
    .thrWrite(thrWrite), .thrChannel(thrChannel), .thrSel(thrSel), .thrData(thrData),
    .stickyClear(stickyClear), .alarm(alarm), .alarmSticky(alarmSticky),
    .avgValid(avgValid), .avgChannel(avgChannel), .avgData(avgData),
    .timeoutError(timeoutError), .dbgState(dbgState)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic resetDut();
    reset       = 1'b0;
    enable      = '0;
    sampleValid = 1'b0;
    sampleData  = '0;
    thrWrite    = 1'b0;
    stickyClear = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // driver tasks
  task automatic writeThr(input logic [ChW-1:0] ch, input logic sel, input logic [DataWidth-1:0] val);
    thrWrite = 1'b1; thrChannel = ch; thrSel = sel; thrData = val;
    @(negedge clock);
    thrWrite = 1'b0;
  endtask

  task automatic waitConvStart();
    int n = 0;
    while (convStart !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (convStart !== 1'b1) checkVal("convStartTimeout", 0, 1);
  endtask

  // ADC model: answers in the third cycle after the convStart cycle; returns
  // at the negedge of the cycle after the sampleValid cycle.
  task automatic doConv(input logic [DataWidth-1:0] data, input int expCh);
    waitConvStart();
    checkVal("convChannel", convChannel, expCh);
    if (convChannel == 2'd2) ch2Requests++;
    @(negedge clock);
    checkVal("convStartPulse", convStart, 0);
    repeat (2) @(negedge clock);
    checkVal("convChannelHold", convChannel, expCh);
    sampleData  = data;
    sampleValid = 1'b1;
    @(negedge clock);
    sampleValid = 1'b0;
  endtask

  task automatic finishConv(input bit expValid, input int expCh, input int expData);
    checkVal("avgValidEarly", avgValid, 0);
    @(negedge clock);
    checkVal("avgValid", avgValid, expValid);
    if (expValid) begin
      checkVal("avgChannel", avgChannel, expCh);
      checkVal("avgData", avgData, expData);
    end
  endtask

  task automatic avgOf(input logic [DataWidth-1:0] v);
    for (int i = 0; i < 3; i++) begin
      doConv(v, 0);
      finishConv(1'b0, 0, 0);
    end
    doConv(v, 0);
    finishConv(1'b1, 0, v);
  endtask

  initial begin
    thrChannel = '0; thrSel = 1'b0; thrData = '0;
    reset = 1'b0; enable = '0; sampleValid = 1'b0; sampleData = '0;
    thrWrite = 1'b0; stickyClear = '0;
    repeat (3) @(negedge clock);
    checkVal("rstConvStart", convStart, 0);
    checkVal("rstConvChannel", convChannel, 0);
    checkVal("rstAvgValid", avgValid, 0);
    checkVal("rstAvgChannel", avgChannel, 0);
    checkVal("rstAvgData", avgData, 0);
    checkVal("rstAlarm", alarm, 0);
    checkVal("rstSticky", alarmSticky, 0);
    checkVal("rstTimeout", timeoutError, 0);
    checkVal("rstState", dbgState, 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checkVal("idleNoEnable", dbgState, 0);
    checkVal("idleNoConv", convStart, 0);

    // scan order with channel 2 masked
    resetDut();
    enable = 4'b1011;
    exp_q = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    while (exp_q.size() > 0) begin
      doConv(16'd50, exp_q.pop_front());
      finishConv(1'b0, 0, 0);
    end
    checkVal("ch2NeverRequested", ch2Requests, 0);

    // averaging: (100+101+102+104)/4 = 101
    resetDut();
    enable = 4'b0001;
    doConv(16'd100, 0); finishConv(1'b0, 0, 0);
    doConv(16'd101, 0); finishConv(1'b0, 0, 0);
    doConv(16'd102, 0); finishConv(1'b0, 0, 0);
    doConv(16'd104, 0); finishConv(1'b1, 0, 101);
    checkVal("avgNoAlarm", alarm, 0);
    @(negedge clock);
    checkVal("avgValidOneCycle", avgValid, 0);

    // hysteresis high=200 low=150
    resetDut();
    writeThr(2'd0, 1'b0, 16'd200);
    writeThr(2'd0, 1'b1, 16'd150);
    enable = 4'b0001;
    avgOf(16'd201);
    checkVal("hys201Alarm", alarm[0], 1);
    checkVal("hys201Sticky", alarmSticky[0], 1);
    avgOf(16'd150);
    checkVal("hysEqLowHold", alarm[0], 1);
    avgOf(16'd149);
    checkVal("hys149Alarm", alarm[0], 0);
    checkVal("hys149Sticky", alarmSticky[0], 1);
    stickyClear = 4'b0001;
    @(negedge clock);
    stickyClear = '0;
    checkVal("stickyCleared", alarmSticky[0], 0);
    avgOf(16'd200);
    checkVal("hysEqHighNoSet", alarm[0], 0);

    // sticky set vs clear collision, plus threshold write during UPDATE
    for (int i = 0; i < 3; i++) begin
      doConv(16'd201, 0);
      finishConv(1'b0, 0, 0);
    end
    doConv(16'd201, 0);
    stickyClear = 4'b0001;
    thrWrite = 1'b1; thrChannel = 2'd0; thrSel = 1'b0; thrData = 16'd255;
    finishConv(1'b1, 0, 201);
    stickyClear = '0;
    thrWrite    = 1'b0;
    checkVal("simulAlarm", alarm[0], 1);
    checkVal("simulStickySetWins", alarmSticky[0], 1);
    avgOf(16'd100);
    checkVal("lowClears", alarm[0], 0);
    avgOf(16'd230);
    checkVal("newHighUsed", alarm[0], 0);
    checkVal("stickyHeld", alarmSticky[0], 1);

    // timeout on channel 1, its accumulator untouched
    resetDut();
    enable = 4'b0011;
    doConv(16'd100, 0); finishConv(1'b0, 0, 0);
    waitConvStart();
    checkVal("toChannel", convChannel, 1);
    sampleData = 16'd1000;
    repeat (16) @(negedge clock);
    checkVal("toNotYet", timeoutError, 0);
    @(negedge clock);
    checkVal("toSet", timeoutError, 1);
    doConv(16'd104, 0); finishConv(1'b0, 0, 0);
    doConv(16'd40, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd108, 0); finishConv(1'b0, 0, 0);
    doConv(16'd44, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd112, 0); finishConv(1'b1, 0, 106);
    doConv(16'd48, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd1, 0);   finishConv(1'b0, 0, 0);
    doConv(16'd52, 1);  finishConv(1'b1, 1, 46);
    checkVal("toSticky", timeoutError, 1);

    // reset mid-WAIT with a stale strobe on the release cycle
    resetDut();
    enable = 4'b0011;
    doConv(16'd7, 0); finishConv(1'b0, 0, 0);
    waitConvStart();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkVal("abortConvStart", convStart, 0);
    checkVal("abortState", dbgState, 0);
    checkVal("abortConvChannel", convChannel, 0);
    reset       = 1'b1;
    sampleValid = 1'b1;
    sampleData  = 16'd500;
    @(negedge clock);
    sampleValid = 1'b0;
    doConv(16'd10, 0); finishConv(1'b0, 0, 0);
    doConv(16'd5, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd20, 0); finishConv(1'b0, 0, 0);
    doConv(16'd5, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd30, 0); finishConv(1'b0, 0, 0);
    doConv(16'd5, 1);  finishConv(1'b0, 0, 0);
    doConv(16'd40, 0); finishConv(1'b1, 0, 25);
    checkVal("rstTimeoutCleared", timeoutError, 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
